// File: rtl/bcd_updown_counter_if.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter_if
// Control/data bundle for the BCD up/down counter.
//
// Parameter:
//   DIGITS  number of BCD digits (1..8); W = 4*DIGITS
//
// Signals:
//   en    count enable                          (master -> slave)
//   up    direction, 1 = up, 0 = down           (master -> slave)
//   load  synchronous parallel load             (master -> slave)
//   din   load value, packed BCD                (master -> slave)
//   max   terminal value, packed BCD            (master -> slave)
//   dout  current count, packed BCD             (slave -> master)
//   tc    combinational terminal-count flag     (slave -> master)
//   cout  registered carry pulse                (slave -> master)
//   bout  registered borrow pulse               (slave -> master)
//   err   registered load-error pulse           (slave -> master)
// -----------------------------------------------------------------------------
interface bcd_updown_counter_if #(
    parameter int DIGITS = 2
);
    localparam int W = 4 * DIGITS;

    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] din;
    logic [W-1:0] max;
    logic [W-1:0] dout;
    logic         tc;
    logic         cout;
    logic         bout;
    logic         err;

    modport master (
        output en, up, load, din, max,
        input  dout, tc, cout, bout, err
    );

    modport slave (
        input  en, up, load, din, max,
        output dout, tc, cout, bout, err
    );
endinterface

// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
// Parametrised N-digit BCD up/down counter with a runtime-programmable
// terminal value, synchronous parallel load and one-cycle carry/borrow pulses.
// Intended as a cascadable decimal timebase: tc is combinational so it can
// drive the enable of the next stage directly.
//
// Parameter:
//   DIGITS  number of BCD digits (1..8)
//
// Ports:
//   clk   clock, rising-edge active
//   rst   asynchronous reset, active-high
//   bus   bcd_updown_counter_if.slave (en, up, load, din, max in;
//         dout, tc, cout, bout, err out)
//
// Per-edge priority: rst > load > en. With neither load nor en the count
// holds and all pulse outputs return to 0.
//
// Optional feature macro: BCD_CNT_CHK_EN
//   defined   : loads with a non-BCD digit or din > max are rejected; the
//               count holds and err pulses for one cycle.
//   undefined : din is loaded unchecked and err is held at 0.
// -----------------------------------------------------------------------------
module bcd_updown_counter #(
    parameter int DIGITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_updown_counter_if.slave  bus
);
    localparam int W = 4 * DIGITS;

    // BCD increment: each digit at 9 or above rolls to 0 and carries on;
    // the first digit below 9 absorbs the carry.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // BCD decrement: a 0 digit becomes 9 and borrows on; any other digit
    // (including out-of-range ones above 9) decrements in binary.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

`ifdef BCD_CNT_CHK_EN
    // True when every digit of v is a legal decimal digit (0..9).
    function automatic logic bcd_digits_ok(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction
`endif

    logic [W-1:0] dout_q, dout_d;
    logic         cout_q, cout_d;
    logic         bout_q, bout_d;
    logic         err_q,  err_d;

    // Next-state computation: load, up-count with wrap to 0, down-count with
    // wrap to max. Pulses default to 0 so they last exactly one cycle.
    always_comb begin
        dout_d = dout_q;
        cout_d = 1'b0;
        bout_d = 1'b0;
        err_d  = 1'b0;
        if (bus.load) begin
`ifdef BCD_CNT_CHK_EN
            if (!bcd_digits_ok(bus.din) || (bus.din > bus.max)) begin
                err_d = 1'b1;
            end else begin
                dout_d = bus.din;
            end
`else
            dout_d = bus.din;
`endif
        end else if (bus.en) begin
            if (bus.up) begin
                // Unsigned compare of the packed vectors also catches a max
                // that has been lowered beneath the current count.
                if (dout_q >= bus.max) begin
                    dout_d = {W{1'b0}};
                    cout_d = 1'b1;
                end else begin
                    dout_d = bcd_inc(dout_q);
                end
            end else begin
                if (dout_q == {W{1'b0}}) begin
                    dout_d = bus.max;
                    bout_d = 1'b1;
                end else begin
                    dout_d = bcd_dec(dout_q);
                end
            end
        end else begin
            dout_d = dout_q;
        end
    end

    // State and pulse registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= {W{1'b0}};
            cout_q <= 1'b0;
            bout_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            cout_q <= cout_d;
            bout_q <= bout_d;
            err_q  <= err_d;
        end
    end

    assign bus.dout = dout_q;
    assign bus.cout = cout_q;
    assign bus.bout = bout_q;
    assign bus.err  = err_q;
    // Terminal count is combinational and ignores en so it can cascade.
    assign bus.tc   = bus.up ? (dout_q >= bus.max) : (dout_q == {W{1'b0}});

endmodule

// File: tb/tb_bcd_updown_counter.sv
module tb_bcd_updown_counter;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_mis;
    int   k;
    logic [7:0] exp_dn [7];
    logic       exp_bo [7];

    bcd_updown_counter_if #(.DIGITS(2)) if2 ();
    bcd_updown_counter_if #(.DIGITS(3)) if3 ();

    bcd_updown_counter #(.DIGITS(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
    bcd_updown_counter #(.DIGITS(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_mis = n_mis + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        exp_dn = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h23, 8'h22};
        exp_bo = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        rst = 1'b1;
        if2.en = 1'b0; if2.up = 1'b0; if2.load = 1'b0; if2.din = 8'h00; if2.max = 8'h99;
        if3.en = 1'b0; if3.up = 1'b1; if3.load = 1'b0; if3.din = 12'h000; if3.max = 12'h999;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_dout", 32'(if2.dout), 32'h0);
        chk("rst_cout", 32'(if2.cout), 32'h0);
        chk("rst_bout", 32'(if2.bout), 32'h0);
        chk("rst_err",  32'(if2.err),  32'h0);
        chk("rst_tc_down", 32'(if2.tc), 32'h1);

        // Full up sweep 00..99 -> 00
        if2.up = 1'b1; if2.en = 1'b1;
        k = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            k = (k == 99) ? 0 : k + 1;
            chk("up_dout", 32'(if2.dout), 32'(((k / 10) << 4) | (k % 10)));
            chk("up_cout", 32'(if2.cout), 32'(k == 0));
            chk("up_tc",   32'(if2.tc),   32'(k == 99));
        end

        // Load 05 then count down through the wrap at MAX=23
        if2.en = 1'b0; if2.load = 1'b1; if2.din = 8'h05; if2.max = 8'h23; if2.up = 1'b0;
        step();
        chk("ld05_dout", 32'(if2.dout), 32'h05);
        if2.load = 1'b0; if2.en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("dn_dout", 32'(if2.dout), 32'(exp_dn[i]));
            chk("dn_bout", 32'(if2.bout), 32'(exp_bo[i]));
            chk("dn_cout", 32'(if2.cout), 32'h0);
        end

        // Three-digit ripple carry and borrow
        if3.load = 1'b1; if3.din = 12'h199;
        step();
        if3.load = 1'b0; if3.en = 1'b1; if3.up = 1'b1;
        step();
        chk("d3_up_dout", 32'(if3.dout), 32'h200);
        chk("d3_up_cout", 32'(if3.cout), 32'h0);
        if3.en = 1'b0; if3.load = 1'b1; if3.din = 12'h200;
        step();
        if3.load = 1'b0; if3.en = 1'b1; if3.up = 1'b0;
        step();
        chk("d3_dn_dout", 32'(if3.dout), 32'h199);
        chk("d3_dn_bout", 32'(if3.bout), 32'h0);
        if3.en = 1'b0;

        // MAX lowered below the current count
        if2.en = 1'b0; if2.load = 1'b1; if2.din = 8'h47; if2.max = 8'h59; if2.up = 1'b1;
        step();
        if2.load = 1'b0;
        chk("max59_tc", 32'(if2.tc), 32'h0);
        if2.max = 8'h30;
        #1;
        chk("max30_tc", 32'(if2.tc), 32'h1);
        if2.en = 1'b1;
        step();
        chk("max30_dout", 32'(if2.dout), 32'h00);
        chk("max30_cout", 32'(if2.cout), 32'h1);

        // MAX = 0: stays at 0, pulses every enabled edge
        if2.max = 8'h00;
        step();
        chk("max0_up_dout", 32'(if2.dout), 32'h00);
        chk("max0_up_cout", 32'(if2.cout), 32'h1);
        if2.up = 1'b0;
        step();
        chk("max0_dn_dout", 32'(if2.dout), 32'h00);
        chk("max0_dn_bout", 32'(if2.bout), 32'h1);
        chk("max0_dn_cout", 32'(if2.cout), 32'h0);

        // Hold clears the pulses
        if2.en = 1'b0;
        step();
        chk("hold_bout", 32'(if2.bout), 32'h0);

        // LOAD beats EN
        if2.max = 8'h99; if2.up = 1'b1; if2.en = 1'b1; if2.load = 1'b1; if2.din = 8'h12;
        step();
        chk("ldpri_dout", 32'(if2.dout), 32'h12);
        chk("ldpri_cout", 32'(if2.cout), 32'h0);
        chk("ldpri_bout", 32'(if2.bout), 32'h0);
        if2.load = 1'b0; if2.en = 1'b0;

        // Asynchronous reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        chk("arst_dout", 32'(if2.dout), 32'h00);
        step();
        rst = 1'b0;
        if2.en = 1'b1; if2.up = 1'b1;
        step();
        chk("post_rst_dout", 32'(if2.dout), 32'h01);
        if2.en = 1'b0;

        // Load checking
        if2.max = 8'h50; if2.load = 1'b1; if2.din = 8'h33;
        step();
        chk("ld33_dout", 32'(if2.dout), 32'h33);
        if2.din = 8'h1A;
        step();
`ifdef BCD_CNT_CHK_EN
        chk("ld1a_dout", 32'(if2.dout), 32'h33);
        chk("ld1a_err",  32'(if2.err),  32'h1);
        if2.din = 8'h60;
        step();
        chk("ld60_dout", 32'(if2.dout), 32'h33);
        chk("ld60_err",  32'(if2.err),  32'h1);
`else
        chk("ld1a_dout", 32'(if2.dout), 32'h1A);
        chk("ld1a_err",  32'(if2.err),  32'h0);
        if2.load = 1'b0; if2.en = 1'b1; if2.up = 1'b0;
        step();
        chk("dn1a_dout", 32'(if2.dout), 32'h19);
        if2.en = 1'b0; if2.load = 1'b1;
`endif
        if2.din = 8'h42;
        step();
        chk("ld42_dout", 32'(if2.dout), 32'h42);
        chk("ld42_err",  32'(if2.err),  32'h0);
        if2.load = 1'b0;
        step();
        chk("idle_err", 32'(if2.err), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
